hm01b0_sensor_model: RTL and testbench



---
 rtl/hm01b0_sensor_model_if.sv | 10 +
 rtl/hm01b0_sensor_model.sv | 81 ++++++++
 tb/tb_hm01b0_sensor_model.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/hm01b0_sensor_model_if.sv
// rtl/hm01b0_sensor_model_if.sv - HM01B0 parallel video output bundle
interface hm01b0_sensor_model_if;
   logic       clock;
   logic [7:0] pixdata;
   logic       hsync;
   logic       vsync;

   modport master (output clock, pixdata, hsync, vsync);
   modport slave  (input  clock, pixdata, hsync, vsync);
endinterface

// File: rtl/hm01b0_sensor_model.sv
// rtl/hm01b0_sensor_model.sv - HM01B0 camera model streaming one stored greyscale frame
module hm01b0_sensor_model #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int HBLANK = 32,
   parameter int VBLANK = 8
) (
   input  logic                   mclk,
   input  logic                   nreset,
   hm01b0_sensor_model_if.master  vid
);
   localparam int COLS   = WIDTH + HBLANK;
   localparam int ROWS   = HEIGHT + VBLANK;
   localparam int PIXELS = WIDTH * HEIGHT;
   localparam int CW     = $clog2(COLS);
   localparam int RW     = $clog2(ROWS);
   localparam int AW     = $clog2(PIXELS);

   // Frame store, row-major; filled from outside by hierarchical access
   logic [7:0]    hm01b0_image [PIXELS];

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic [7:0]    pixdata_q, pixdata_d;
   logic          active;
   logic [AW-1:0] addr;

   // Raster position: column wraps after the line blank, row wraps after the frame blank
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (col_q == CW'(COLS - 1)) begin
         col_d = '0;
         if (row_q == RW'(ROWS - 1)) begin
            row_d = '0;
         end else begin
            row_d = row_q + 1'b1;
         end
      end else begin
         col_d = col_q + 1'b1;
      end
   end

   // Video qualifiers and pixel value for the current raster position
   always_comb begin
      vsync_d   = (row_q < RW'(HEIGHT));
      active    = vsync_d && (col_q < CW'(WIDTH));
      hsync_d   = active;
      addr      = '0;
      pixdata_d = 8'h00;
      if (active) begin
         addr      = AW'(row_q) * AW'(WIDTH) + AW'(col_q);
         pixdata_d = hm01b0_image[addr];
      end
   end

   // Outputs launch on the falling edge so the consumer gets half a period either side of its rising edge
   always_ff @(negedge mclk or negedge nreset) begin
      if (!nreset) begin
         col_q     <= '0;
         row_q     <= '0;
         hsync_q   <= 1'b0;
         vsync_q   <= 1'b0;
         pixdata_q <= 8'h00;
      end else begin
         col_q     <= col_d;
         row_q     <= row_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         pixdata_q <= pixdata_d;
      end
   end

   // Pixel clock is held low during reset so the consumer sees no edges
   assign vid.clock   = mclk & nreset;
   assign vid.hsync   = hsync_q;
   assign vid.vsync   = vsync_q;
   assign vid.pixdata = pixdata_q;
endmodule

// File: tb/tb_hm01b0_sensor_model.sv
// tb/tb_hm01b0_sensor_model.sv - scoreboard bench for the HM01B0 sensor model
`timescale 1ns/1ps
module tb_hm01b0_sensor_model;
   localparam int W     = 320;
   localparam int H     = 64;
   localparam int HB    = 32;
   localparam int VB    = 8;
   localparam int LINE  = W + HB;
   localparam int FRAME = (H + VB) * LINE;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic [7:0] pix;
   } samp_t;

   logic mclk   = 1'b0;
   logic nreset = 1'b0;

   hm01b0_sensor_model_if vif ();

   hm01b0_sensor_model #(
      .WIDTH (W),
      .HEIGHT(H),
      .HBLANK(HB),
      .VBLANK(VB)
   ) dut (
      .mclk  (mclk),
      .nreset(nreset),
      .vid   (vif.master)
   );

   always #1250 mclk = ~mclk;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] img [W*H];
   samp_t      exp_q [$];
   int         mrow, mcol, cyc;

   int         hs_rises, first_rise_cyc, rise64_cyc, line_act, lines_seen;
   int         vs_hi, vs_lo, vs_fall_cyc;
   logic [7:0] rise64_pix, nf_pix, prev_px;
   logic       nf_hs, prev_hs, prev_vs, chk_alt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   task automatic reset_stats();
      hs_rises = 0; first_rise_cyc = -1; rise64_cyc = -1; line_act = 0; lines_seen = 0;
      vs_hi = 0; vs_lo = 0; vs_fall_cyc = -1;
      rise64_pix = 8'h00; nf_pix = 8'h00; nf_hs = 1'b0;
      prev_hs = 1'b0; prev_vs = 1'b0; prev_px = 8'h00;
   endtask

   task automatic load_image();
      for (int i = 0; i < W*H; i++) dut.hm01b0_image[i] = img[i];
   endtask

   // Reference raster: expected sample for each pixel-clock cycle since reset release
   task automatic model_push(input int n);
      samp_t s;
      for (int i = 0; i < n; i++) begin
         s.vs  = (mrow < H);
         s.hs  = s.vs && (mcol < W);
         s.pix = s.hs ? img[mrow*W + mcol] : 8'h00;
         exp_q.push_back(s);
         if (mcol == LINE - 1) begin
            mcol = 0;
            mrow = (mrow == H + VB - 1) ? 0 : mrow + 1;
         end else begin
            mcol++;
         end
      end
   endtask

   task automatic release_reset();
      @(posedge mclk);
      #10;
      nreset = 1'b1;
      mrow = 0; mcol = 0; cyc = 0;
      exp_q.delete();
      reset_stats();
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_clock"}, vif.clock, 1'b0);
      check_eq({tag, "_hsync"}, vif.hsync, 1'b0);
      check_eq({tag, "_vsync"}, vif.vsync, 1'b0);
      check_eq({tag, "_pixdata"}, vif.pixdata, 8'h00);
   endtask

   task automatic run(input int n);
      samp_t      e;
      logic       hs, vs;
      logic [7:0] px, alt;
      model_push(n);
      for (int i = 0; i < n; i++) begin
         @(posedge mclk);
         #1;
         e  = exp_q.pop_front();
         hs = vif.hsync;
         vs = vif.vsync;
         px = vif.pixdata;
         check_eq("hsync", hs, e.hs);
         check_eq("vsync", vs, e.vs);
         check_eq("pixdata", px, e.pix);
         check_eq("clock", vif.clock, 1'b1);
         if (hs && !prev_hs) begin
            hs_rises++;
            if (hs_rises == 1) first_rise_cyc = cyc;
            if (hs_rises == 64) begin
               rise64_cyc = cyc;
               rise64_pix = px;
            end
         end
         if (hs) line_act++;
         if (!hs && prev_hs) begin
            lines_seen++;
            check_eq("line_len", line_act, W);
            line_act = 0;
         end
         if (cyc < FRAME) begin
            if (vs) vs_hi++;
            else    vs_lo++;
         end
         if (!vs && prev_vs && vs_fall_cyc < 0) vs_fall_cyc = cyc;
         if (cyc == FRAME) begin
            nf_pix = px;
            nf_hs  = hs;
         end
         alt = ~prev_px;
         if (chk_alt && hs && prev_hs) check_eq("alternate", px, alt);
         prev_hs = hs;
         prev_vs = vs;
         prev_px = px;
         cyc++;
      end
   endtask

   initial begin
      chk_alt = 1'b0;
      reset_stats();
      for (int i = 0; i < W*H; i++) img[i] = 8'(i % 256);

      // Reset held with mclk running
      for (int i = 0; i < 4; i++) begin
         @(posedge mclk);
         #1;
         check_idle("rst");
      end
      load_image();

      // Ramp image: one full frame plus the first line of the next
      release_reset();
      run(FRAME + LINE);
      check_eq("first_rise_cyc", first_rise_cyc, 0);
      check_eq("rise64_dist", rise64_cyc - first_rise_cyc, 63 * LINE);
      check_eq("rise64_pix", rise64_pix, img[63*W]);
      check_eq("vs_hi", vs_hi, H * LINE);
      check_eq("vs_lo", vs_lo, VB * LINE);
      check_eq("vs_fall_cyc", vs_fall_cyc, H * LINE);
      check_eq("next_frame_hs", nf_hs, 1'b1);
      check_eq("next_frame_pix", nf_pix, img[0]);

      // Asynchronous reset in the middle of row 5
      nreset = 1'b0;
      release_reset();
      run(5 * LINE + 100);
      check_eq("mid_hsync_before", vif.hsync, 1'b1);
      #300;
      nreset = 1'b0;
      #1;
      check_idle("async");
      for (int i = 0; i < 3; i++) begin
         @(negedge mclk);
         #1;
         check_idle("hold");
      end
      release_reset();
      run(LINE + 10);
      check_eq("restart_line_len_seen", lines_seen, 1);

      // Checkerboard image: pixels alternate along every line
      nreset = 1'b0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            img[r*W + c] = ((r + c) % 2 == 1) ? 8'hFF : 8'h00;
      load_image();
      release_reset();
      chk_alt = 1'b1;
      run(FRAME);
      chk_alt = 1'b0;
      check_eq("cb_lines", lines_seen, H);
      check_eq("cb_rises", hs_rises, H);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
